// File: rtl/wwm_turn_ctrl_if.sv
// Bundle between the artillery turn controller, the input/debounce front end and the VGA renderer.
// The controller takes the slave view; whatever drives buttons and reads the projectile takes the master view.
interface wwm_turn_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 10,
    parameter int VEL_W       = 6
);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic                             Start;
    logic                             Ack;
    logic                             Fire;
    logic                             tick;
    logic signed [VEL_W-1:0]          vX;
    logic signed [VEL_W-1:0]          vY;
    logic [NUM_PLAYERS*COORD_W-1:0]   pos_x;
    logic [NUM_PLAYERS*COORD_W-1:0]   pos_y;

    logic                             q_I;
    logic                             q_Aim;
    logic                             q_Flight;
    logic                             q_Done;
    logic [PW-1:0]                    cur_player;
    logic [COORD_W-1:0]               proj_x;
    logic [COORD_W-1:0]               proj_y;
    logic                             proj_valid;
    logic [PW-1:0]                    winner;

    modport master (
        output Start, Ack, Fire, tick, vX, vY, pos_x, pos_y,
        input  q_I, q_Aim, q_Flight, q_Done, cur_player, proj_x, proj_y, proj_valid, winner
    );

    modport slave (
        input  Start, Ack, Fire, tick, vX, vY, pos_x, pos_y,
        output q_I, q_Aim, q_Flight, q_Done, cur_player, proj_x, proj_y, proj_valid, winner
    );
endinterface

// File: rtl/wwm_turn_ctrl.sv
// Turn sequencer for the artillery game: rotates shooters through aim/fire, integrates the
// projectile once per frame tick under gravity, and resolves hits, out-of-arena misses and timeouts.
module wwm_turn_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 10,
    parameter int VEL_W       = 6,
    parameter int GRAVITY     = 1,
    parameter int XMIN        = 160,
    parameter int XMAX        = 775,
    parameter int YMIN        = 50,
    parameter int YMAX        = 475,
    parameter int HIT_HX      = 12,
    parameter int HIT_HY      = 12,
    parameter int MAX_TICKS   = 255
) (
    input  logic          clk,
    input  logic          Reset_n,
    wwm_turn_ctrl_if.slave bus
);
    localparam int PW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int SW   = COORD_W + 2;
    localparam int CW   = $clog2(MAX_TICKS + 1);
    localparam int VMAX = (1 << (VEL_W - 1)) - 1;

    localparam logic signed [SW-1:0] XMIN_S = SW'(XMIN);
    localparam logic signed [SW-1:0] XMAX_S = SW'(XMAX);
    localparam logic signed [SW-1:0] YMIN_S = SW'(YMIN);
    localparam logic signed [SW-1:0] YMAX_S = SW'(YMAX);
    localparam logic signed [SW-1:0] HX_S   = SW'(HIT_HX);
    localparam logic signed [SW-1:0] HY_S   = SW'(HIT_HY);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_AIM    = 4'b0010,
        S_FLIGHT = 4'b0100,
        S_DONE   = 4'b1000
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           cur_q, cur_d;
    logic [PW-1:0]           win_q, win_d;
    logic [COORD_W-1:0]      px_q, px_d;
    logic [COORD_W-1:0]      py_q, py_d;
    logic signed [VEL_W-1:0] vx_q, vx_d;
    logic signed [VEL_W-1:0] vy_q, vy_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic signed [SW-1:0]    nx, ny;
    logic                    hit, oob, timeout;
    logic [PW-1:0]           cur_next;

    function automatic logic signed [SW-1:0] ext_pos(input logic [COORD_W-1:0] p);
        return $signed({2'b00, p});
    endfunction

    function automatic logic signed [SW-1:0] ext_vel(input logic signed [VEL_W-1:0] v);
        return $signed({{(SW - VEL_W){v[VEL_W-1]}}, v});
    endfunction

    function automatic logic in_box(input logic signed [SW-1:0] d, input logic signed [SW-1:0] lim);
        return (d <= lim) && (d >= -lim);
    endfunction

    // Gravity only ever pushes vy upward, so only the positive rail needs clamping.
    function automatic logic signed [VEL_W-1:0] sat_gravity(input logic signed [VEL_W-1:0] v);
        int s;
        s = int'(v) + GRAVITY;
        if (s > VMAX) begin
            s = VMAX;
        end
        return s[VEL_W-1:0];
    endfunction

    always_comb begin
        nx = ext_pos(px_q) + ext_vel(vx_q);
        ny = ext_pos(py_q) + ext_vel(vy_q);
    end

    // The shooter's own box is skipped so a projectile launched from its centre cannot self-hit.
    always_comb begin
        hit = 1'b0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if ((PW'(j) != cur_q) &&
                in_box(nx - ext_pos(bus.pos_x[j*COORD_W +: COORD_W]), HX_S) &&
                in_box(ny - ext_pos(bus.pos_y[j*COORD_W +: COORD_W]), HY_S)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        oob      = (nx < XMIN_S) || (nx > XMAX_S) || (ny < YMIN_S) || (ny > YMAX_S);
        timeout  = (cnt_q == CW'(MAX_TICKS - 1));
        cur_next = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        win_d   = win_q;
        px_d    = px_q;
        py_d    = py_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_AIM;
                    cur_d   = '0;
                end
            end
            S_AIM: begin
                if (bus.Fire) begin
                    state_d = S_FLIGHT;
                    px_d    = bus.pos_x[cur_q*COORD_W +: COORD_W];
                    py_d    = bus.pos_y[cur_q*COORD_W +: COORD_W];
                    vx_d    = bus.vX;
                    vy_d    = bus.vY;
                    cnt_d   = '0;
                end
            end
            S_FLIGHT: begin
                if (bus.tick) begin
                    if (hit) begin
                        state_d = S_DONE;
                        win_d   = cur_q;
                        px_d    = nx[COORD_W-1:0];
                        py_d    = ny[COORD_W-1:0];
                    end else if (oob || timeout) begin
                        state_d = S_AIM;
                        cur_d   = cur_next;
                    end else begin
                        px_d  = nx[COORD_W-1:0];
                        py_d  = ny[COORD_W-1:0];
                        vy_d  = sat_gravity(vy_q);
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            win_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            win_q   <= win_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output comes straight off a flop; the one-hot state bits double as the q_* lines.
    assign bus.q_I        = state_q[0];
    assign bus.q_Aim      = state_q[1];
    assign bus.q_Flight   = state_q[2];
    assign bus.q_Done     = state_q[3];
    assign bus.proj_valid = state_q[2];
    assign bus.cur_player = cur_q;
    assign bus.winner     = win_q;
    assign bus.proj_x     = px_q;
    assign bus.proj_y     = py_q;
endmodule

// File: tb/tb_wwm_turn_ctrl.sv
// Bench for wwm_turn_ctrl: two configurations side by side (2 players with gravity, 3 players
// without gravity and a 4-tick timeout), directed scenarios plus randomized play against a game model.
module tb_wwm_turn_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start, ack, fire, tck;
    logic signed [5:0] vx_in, vy_in;
    int                pAx[8], pAy[8], pBx[8], pBy[8];
    int                n_cmp, n_bad;

    wwm_turn_ctrl_if #(.NUM_PLAYERS(2), .COORD_W(10), .VEL_W(6)) ifA ();
    wwm_turn_ctrl_if #(.NUM_PLAYERS(3), .COORD_W(10), .VEL_W(6)) ifB ();

    assign ifA.Start = start;  assign ifB.Start = start;
    assign ifA.Ack   = ack;    assign ifB.Ack   = ack;
    assign ifA.Fire  = fire;   assign ifB.Fire  = fire;
    assign ifA.tick  = tck;    assign ifB.tick  = tck;
    assign ifA.vX    = vx_in;  assign ifB.vX    = vx_in;
    assign ifA.vY    = vy_in;  assign ifB.vY    = vy_in;

    always_comb begin
        ifA.pos_x = '0;
        ifA.pos_y = '0;
        ifB.pos_x = '0;
        ifB.pos_y = '0;
        for (int i = 0; i < 2; i++) begin
            ifA.pos_x[i*10 +: 10] = 10'(pAx[i]);
            ifA.pos_y[i*10 +: 10] = 10'(pAy[i]);
        end
        for (int i = 0; i < 3; i++) begin
            ifB.pos_x[i*10 +: 10] = 10'(pBx[i]);
            ifB.pos_y[i*10 +: 10] = 10'(pBy[i]);
        end
    end

    wwm_turn_ctrl #(.NUM_PLAYERS(2), .GRAVITY(1), .MAX_TICKS(255)) dut_a (
        .clk(clk), .Reset_n(rst_n), .bus(ifA)
    );
    wwm_turn_ctrl #(.NUM_PLAYERS(3), .GRAVITY(0), .MAX_TICKS(4)) dut_b (
        .clk(clk), .Reset_n(rst_n), .bus(ifB)
    );

    // Game model: 0 idle, 1 aim, 2 flight, 3 done; all quantities plain integers.
    typedef struct {
        int st;
        int cur;
        int px;
        int py;
        int vx;
        int vy;
        int cnt;
        int win;
    } mdl_t;

    mdl_t mA, mB;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.cur = 0; r.px = 0; r.py = 0; r.vx = 0; r.vy = 0; r.cnt = 0; r.win = 0;
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int n, input int g, input int mt,
                                   input int posx[8], input int posy[8]);
        mdl_t r;
        int nx, ny;
        bit hit;
        r = m;
        case (m.st)
            0: if (start) begin r.st = 1; r.cur = 0; end
            1: if (fire) begin
                r.st = 2; r.px = posx[m.cur]; r.py = posy[m.cur];
                r.vx = int'(vx_in); r.vy = int'(vy_in); r.cnt = 0;
            end
            2: if (tck) begin
                nx = m.px + m.vx;
                ny = m.py + m.vy;
                hit = 0;
                for (int j = 0; j < n; j++)
                    if (j != m.cur && iabs(nx - posx[j]) <= 12 && iabs(ny - posy[j]) <= 12) hit = 1;
                if (hit) begin
                    r.st = 3; r.win = m.cur; r.px = nx & 1023; r.py = ny & 1023;
                end else if (nx < 160 || nx > 775 || ny < 50 || ny > 475 || m.cnt == mt - 1) begin
                    r.st = 1; r.cur = (m.cur + 1) % n;
                end else begin
                    r.px = nx; r.py = ny;
                    r.vy = (m.vy + g > 31) ? 31 : m.vy + g;
                    r.cnt = m.cnt + 1;
                end
            end
            default: if (ack) r.st = 0;
        endcase
        return r;
    endfunction

    task automatic step();
        mA = mstep(mA, 2, 1, 255, pAx, pAy);
        mB = mstep(mB, 3, 0, 4, pBx, pBy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; ack = 0; fire = 0; tck = 0; vx_in = 0; vy_in = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        mA = mreset();
        mB = mreset();
    endtask

    task automatic test_reset();
        do_reset();
        pAx[0] = 400; pAy[0] = 200; pAx[1] = 700; pAy[1] = 470;
        n_cmp++;
        if ({ifA.q_I, ifA.q_Aim, ifA.q_Flight, ifA.q_Done, ifA.proj_valid} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_idle got %b need 10000",
                     {ifA.q_I, ifA.q_Aim, ifA.q_Flight, ifA.q_Done, ifA.proj_valid});
        end
        start = 1; step(); start = 0;
        vx_in = 5; vy_in = 0; fire = 1; step(); fire = 0;
        tck = 1; step(); tck = 0;
        n_cmp++;
        if ({ifA.q_Flight, ifA.proj_valid, ifA.proj_x, ifA.proj_y} !== {2'b11, 10'd405, 10'd200}) begin
            n_bad++;
            $display("FAIL reset_preflight got fl=%b v=%b (%0d,%0d) need 1 1 (405,200)",
                     ifA.q_Flight, ifA.proj_valid, ifA.proj_x, ifA.proj_y);
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({ifA.q_I, ifA.q_Aim, ifA.q_Flight, ifA.q_Done, ifA.proj_valid, ifA.cur_player,
             ifA.winner, ifA.proj_x, ifA.proj_y} !== {5'b10000, 1'b0, 1'b0, 20'd0}) begin
            n_bad++;
            $display("FAIL reset_midflight got q=%b%b%b%b v=%b cur=%0d (%0d,%0d) need 1000 0 0 (0,0)",
                     ifA.q_I, ifA.q_Aim, ifA.q_Flight, ifA.q_Done, ifA.proj_valid,
                     ifA.cur_player, ifA.proj_x, ifA.proj_y);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        mA = mreset();
        mB = mreset();
        fire = 1; tck = 1; step(); fire = 0; tck = 0;
        n_cmp++;
        if ({ifA.q_I, ifB.q_I} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_stay_idle got %b need 11", {ifA.q_I, ifB.q_I});
        end
    endtask

    task automatic test_hit();
        do_reset();
        pAx[0] = 200; pAy[0] = 460; pAx[1] = 220; pAy[1] = 470;
        start = 1; step(); start = 0;
        vx_in = 10; vy_in = 0; fire = 1; tck = 1; step(); fire = 0; tck = 0;
        n_cmp++;
        if ({ifA.q_Flight, ifA.proj_x, ifA.proj_y} !== {1'b1, 10'd200, 10'd460}) begin
            n_bad++;
            $display("FAIL fire_tick_launch_only got fl=%b (%0d,%0d) need 1 (200,460)",
                     ifA.q_Flight, ifA.proj_x, ifA.proj_y);
        end
        tck = 1; step(); tck = 0;
        n_cmp++;
        if ({ifA.q_Done, ifA.proj_valid, ifA.proj_x, ifA.proj_y, ifA.winner}
            !== {2'b10, 10'd210, 10'd460, 1'b0}) begin
            n_bad++;
            $display("FAIL hit got done=%b v=%b (%0d,%0d) win=%0d need 1 0 (210,460) 0",
                     ifA.q_Done, ifA.proj_valid, ifA.proj_x, ifA.proj_y, ifA.winner);
        end
        start = 1; fire = 1; tck = 1; step(); step(); start = 0; fire = 0; tck = 0;
        n_cmp++;
        if ({ifA.q_Done, ifA.proj_x, ifA.winner} !== {1'b1, 10'd210, 1'b0}) begin
            n_bad++;
            $display("FAIL done_hold got done=%b x=%0d win=%0d need 1 210 0",
                     ifA.q_Done, ifA.proj_x, ifA.winner);
        end
        ack = 1; step(); ack = 0;
        n_cmp++;
        if ({ifA.q_I, ifA.q_Done, ifA.proj_x, ifA.winner} !== {2'b10, 10'd210, 1'b0}) begin
            n_bad++;
            $display("FAIL ack_to_idle got i=%b d=%b x=%0d need 1 0 210", ifA.q_I, ifA.q_Done, ifA.proj_x);
        end
    endtask

    task automatic test_oob_wrap_timeout();
        int xs[2];
        xs[0] = 185; xs[1] = 170;
        do_reset();
        pBx[0] = 200; pBy[0] = 100; pBx[1] = 700; pBy[1] = 470; pBx[2] = 700; pBy[2] = 300;
        start = 1; step(); start = 0;
        vx_in = -15; vy_in = 0; fire = 1; step(); fire = 0;
        for (int k = 0; k < 2; k++) begin
            tck = 1; step(); tck = 0;
            n_cmp++;
            if ({ifB.q_Flight, ifB.proj_x, ifB.proj_y} !== {1'b1, 10'(xs[k]), 10'd100}) begin
                n_bad++;
                $display("FAIL oob_step%0d got fl=%b (%0d,%0d) need 1 (%0d,100)",
                         k + 1, ifB.q_Flight, ifB.proj_x, ifB.proj_y, xs[k]);
            end
        end
        tck = 1; step(); tck = 0;
        n_cmp++;
        if ({ifB.q_Aim, ifB.proj_valid, ifB.cur_player, ifB.proj_x} !== {2'b10, 2'd1, 10'd170}) begin
            n_bad++;
            $display("FAIL oob_miss got aim=%b v=%b cur=%0d x=%0d need 1 0 1 170",
                     ifB.q_Aim, ifB.proj_valid, ifB.cur_player, ifB.proj_x);
        end
        vx_in = 31; vy_in = 0; fire = 1; step(); fire = 0;
        tck = 1; step(); step(); step(); tck = 0;
        n_cmp++;
        if ({ifB.q_Aim, ifB.cur_player, ifB.proj_x, ifB.proj_y} !== {1'b1, 2'd2, 10'd762, 10'd470}) begin
            n_bad++;
            $display("FAIL wrap_second got aim=%b cur=%0d (%0d,%0d) need 1 2 (762,470)",
                     ifB.q_Aim, ifB.cur_player, ifB.proj_x, ifB.proj_y);
        end
        pBx[2] = 400; pBy[2] = 200;
        vx_in = 0; vy_in = 0; fire = 1; step(); fire = 0;
        tck = 1; step(); step(); step(); tck = 0;
        n_cmp++;
        if ({ifB.q_Flight, ifB.proj_x, ifB.proj_y} !== {1'b1, 10'd400, 10'd200}) begin
            n_bad++;
            $display("FAIL self_exclusion got fl=%b (%0d,%0d) need 1 (400,200)",
                     ifB.q_Flight, ifB.proj_x, ifB.proj_y);
        end
        tck = 1; step(); tck = 0;
        n_cmp++;
        if ({ifB.q_Aim, ifB.q_Flight, ifB.cur_player} !== {2'b10, 2'd0}) begin
            n_bad++;
            $display("FAIL timeout_wrap got aim=%b fl=%b cur=%0d need 1 0 0",
                     ifB.q_Aim, ifB.q_Flight, ifB.cur_player);
        end
    endtask

    task automatic test_gravity();
        int ys[8];
        ys[0] = 230; ys[1] = 261; ys[2] = 292; ys[3] = 323;
        ys[4] = 354; ys[5] = 385; ys[6] = 416; ys[7] = 447;
        do_reset();
        pAx[0] = 400; pAy[0] = 200; pAx[1] = 700; pAy[1] = 470;
        start = 1; step(); start = 0;
        vx_in = 0; vy_in = 30; fire = 1; step(); fire = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                fire = 1; start = 1; ack = 1; vx_in = -20; vy_in = -20;
                step(); step();
                fire = 0; start = 0; ack = 0;
                n_cmp++;
                if ({ifA.q_Flight, ifA.proj_x, ifA.proj_y} !== {1'b1, 10'd400, 10'd261}) begin
                    n_bad++;
                    $display("FAIL flight_ignore got fl=%b (%0d,%0d) need 1 (400,261)",
                             ifA.q_Flight, ifA.proj_x, ifA.proj_y);
                end
            end
            tck = 1; step(); tck = 0;
            n_cmp++;
            if ({ifA.q_Flight, ifA.proj_y} !== {1'b1, 10'(ys[k])}) begin
                n_bad++;
                $display("FAIL gravity_step%0d got fl=%b y=%0d need 1 %0d", k + 1, ifA.q_Flight, ifA.proj_y, ys[k]);
            end
        end
        tck = 1; step(); tck = 0;
        n_cmp++;
        if ({ifA.q_Aim, ifA.cur_player, ifA.proj_y} !== {1'b1, 1'b1, 10'd447}) begin
            n_bad++;
            $display("FAIL gravity_floor got aim=%b cur=%0d y=%0d need 1 1 447",
                     ifA.q_Aim, ifA.cur_player, ifA.proj_y);
        end
    endtask

    task automatic randomize_positions();
        for (int i = 0; i < 3; i++) begin
            pAx[i] = $urandom_range(160, 775); pAy[i] = $urandom_range(50, 475);
            pBx[i] = $urandom_range(160, 775); pBy[i] = $urandom_range(50, 475);
        end
        if ($urandom_range(0, 1) == 1) begin
            pAx[1] = pAx[0] + $urandom_range(0, 40) - 20; pAy[1] = pAy[0] + $urandom_range(0, 40) - 20;
            pBx[2] = pBx[1] + $urandom_range(0, 40) - 20; pBy[2] = pBy[1] + $urandom_range(0, 40) - 20;
        end
    endtask

    task automatic test_random();
        logic [26:0] obs_a, exp_a;
        logic [28:0] obs_b, exp_b;
        int v;
        do_reset();
        randomize_positions();
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) randomize_positions();
            start = ($urandom_range(0, 2) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            fire  = ($urandom_range(0, 2) == 0);
            tck   = ($urandom_range(0, 1) == 0);
            v = int'($urandom_range(0, 16)) - 8;
            vx_in = 6'(v);
            v = int'($urandom_range(0, 63)) - 32;
            vy_in = 6'(v);
            step();
            obs_a = {ifA.q_I, ifA.q_Aim, ifA.q_Flight, ifA.q_Done, ifA.proj_valid,
                     ifA.cur_player, ifA.winner, ifA.proj_x, ifA.proj_y};
            exp_a = {mA.st == 0, mA.st == 1, mA.st == 2, mA.st == 3, mA.st == 2,
                     1'(mA.cur), 1'(mA.win), 10'(mA.px), 10'(mA.py)};
            n_cmp++;
            if (obs_a !== exp_a) begin
                n_bad++;
                $display("FAIL random_a cycle %0d got %h need %h", c, obs_a, exp_a);
            end
            obs_b = {ifB.q_I, ifB.q_Aim, ifB.q_Flight, ifB.q_Done, ifB.proj_valid,
                     ifB.cur_player, ifB.winner, ifB.proj_x, ifB.proj_y};
            exp_b = {mB.st == 0, mB.st == 1, mB.st == 2, mB.st == 3, mB.st == 2,
                     2'(mB.cur), 2'(mB.win), 10'(mB.px), 10'(mB.py)};
            n_cmp++;
            if (obs_b !== exp_b) begin
                n_bad++;
                $display("FAIL random_b cycle %0d got %h need %h", c, obs_b, exp_b);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached got running need finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            pAx[i] = 0; pAy[i] = 0; pBx[i] = 0; pBy[i] = 0;
        end
        test_reset();
        test_hit();
        test_oob_wrap_timeout();
        test_gravity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
